// File: rtl/sine_envelope_controller_if.sv
// Control/status bundle between the envelope controller and its driver.
// The slave side (the controller) consumes key/envelope settings and produces the oscillator control words.
interface sine_envelope_controller_if;
   logic        key_on;
   logic [15:0] key_freq;
   logic [30:0] peak_level;
   logic [30:0] sustain_level;
   logic [15:0] attack_step;
   logic [15:0] decay_step;
   logic [15:0] release_step;
   logic [15:0] frequency;
   logic [30:0] amplitude;
   logic [2:0]  env_state;
   logic        busy;

   modport master (
      output key_on, key_freq, peak_level, sustain_level,
             attack_step, decay_step, release_step,
      input  frequency, amplitude, env_state, busy
   );

   modport slave (
      input  key_on, key_freq, peak_level, sustain_level,
             attack_step, decay_step, release_step,
      output frequency, amplitude, env_state, busy
   );
endinterface

// File: rtl/sine_envelope_controller.sv
// ADSR envelope controller producing frequency/amplitude control words for a sine oscillator.
// Amplitude moves only on prescaler ticks; key events take priority over ticks.
module sine_envelope_controller #(
   parameter int CLOCK_FREQUENCY = 50000000,
   parameter int TICK_HZ         = 1000
) (
   input  logic                         clk,
   input  logic                         reset,
   sine_envelope_controller_if.slave    env
);

   localparam int TICK_DIV = CLOCK_FREQUENCY / TICK_HZ;
   localparam int CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } env_state_e;

   // Saturating add capped at lim; a zero step jumps straight to lim.
   function automatic logic [30:0] add_clamp(input logic [30:0] a, input logic [15:0] s,
                                             input logic [30:0] lim);
      logic [31:0] sum;
      logic [30:0] res;
      sum = {1'b0, a} + {16'd0, s};
      if (s == 16'd0 || sum >= {1'b0, lim}) begin
         res = lim;
      end else begin
         res = sum[30:0];
      end
      return res;
   endfunction

   function automatic logic [30:0] sub_clamp(input logic [30:0] a, input logic [15:0] s,
                                             input logic [30:0] lim);
      logic [31:0] diff;
      logic [30:0] res;
      if ({16'd0, s} >= {1'b0, a}) begin
         diff = 32'd0;
      end else begin
         diff = {1'b0, a} - {16'd0, s};
      end
      if (s == 16'd0 || diff <= {1'b0, lim}) begin
         res = lim;
      end else begin
         res = diff[30:0];
      end
      return res;
   endfunction

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             key_q;
   env_state_e       state_q, state_d;
   logic [30:0]      amp_q, amp_d;
   logic [15:0]      freq_q, freq_d;
   logic             busy_q, busy_d;

   logic             tick_s;
   logic             rise_s;
   logic             held_state_s;
   logic [30:0]      sus_s;

   assign tick_s       = (cnt_q == CNT_MAX);
   assign rise_s       = env.key_on & ~key_q;
   assign held_state_s = (state_q == ST_ATTACK) || (state_q == ST_DECAY) ||
                         (state_q == ST_SUSTAIN);
   assign sus_s        = (env.sustain_level < env.peak_level) ? env.sustain_level
                                                              : env.peak_level;

   // Free-running tick prescaler, independent of key activity.
   always_comb begin
      cnt_d = cnt_q;
      if (tick_s) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Envelope next-state: accepted rise, then key low, then tick.
   always_comb begin
      state_d = state_q;
      amp_d   = amp_q;
      freq_d  = freq_q;
      if (rise_s && env.key_freq != 16'd0) begin
         state_d = ST_ATTACK;
         freq_d  = env.key_freq;
      end else if (!env.key_on && held_state_s) begin
         state_d = ST_RELEASE;
      end else if (tick_s) begin
         case (state_q)
            ST_ATTACK: begin
               amp_d   = add_clamp(amp_q, env.attack_step, env.peak_level);
               state_d = (amp_d == env.peak_level) ? ST_DECAY : ST_ATTACK;
            end
            ST_DECAY: begin
               amp_d   = sub_clamp(amp_q, env.decay_step, sus_s);
               state_d = (amp_d == sus_s) ? ST_SUSTAIN : ST_DECAY;
            end
            ST_RELEASE: begin
               amp_d = sub_clamp(amp_q, env.release_step, 31'd0);
               if (amp_d == 31'd0) begin
                  state_d = ST_IDLE;
                  freq_d  = 16'd0;
               end else begin
                  state_d = ST_RELEASE;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end else begin
         state_d = state_q;
      end
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         key_q   <= 1'b0;
         state_q <= ST_IDLE;
         amp_q   <= 31'd0;
         freq_q  <= 16'd0;
         busy_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         key_q   <= env.key_on;
         state_q <= state_d;
         amp_q   <= amp_d;
         freq_q  <= freq_d;
         busy_q  <= busy_d;
      end
   end

   assign env.frequency = freq_q;
   assign env.amplitude = amp_q;
   assign env.env_state = state_q;
   assign env.busy      = busy_q;

endmodule

// File: tb/tb_sine_envelope_controller.sv
// Scoreboard bench: expected output-change events are queued with each stimulus and
// compared in order whenever the DUT's registered outputs change.
module tb_sine_envelope_controller;

   localparam int CLK_HZ = 1000;
   localparam int TICK   = 100;

   typedef struct packed {
      logic [2:0]  st;
      logic [30:0] amp;
      logic [15:0] freq;
   } evt_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc;
   int   n_checks = 0;
   int   n_errors = 0;
   evt_t exp_q[$];
   logic        mon_en = 1'b0;
   logic [50:0] mon_snap;
   logic [50:0] prev_snap;
   evt_t        mon_e;
   int          nwait;

   always #5 clk = ~clk;

   sine_envelope_controller_if env();

   sine_envelope_controller #(.CLOCK_FREQUENCY(CLK_HZ), .TICK_HZ(TICK)) dut (
      .clk   (clk),
      .reset (reset),
      .env   (env)
   );

   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] st, input logic [30:0] amp, input logic [15:0] freq);
      evt_t e;
      e.st = st; e.amp = amp; e.freq = freq;
      exp_q.push_back(e);
   endtask

   task automatic wait_drain(input string tag, input int max_cyc);
      int n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         @(negedge clk); #1;
         n++;
      end
      check_eq(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic push_attack_to_sustain(input logic [15:0] f);
      push(3'd1, 31'd0, f);   push(3'd1, 31'd30, f); push(3'd1, 31'd60, f);
      push(3'd1, 31'd90, f);  push(3'd2, 31'd100, f); push(3'd2, 31'd80, f);
      push(3'd2, 31'd60, f);  push(3'd3, 31'd40, f);
   endtask

   task automatic push_release_from_40(input logic [15:0] f);
      push(3'd4, 31'd40, f); push(3'd4, 31'd30, f); push(3'd4, 31'd20, f);
      push(3'd4, 31'd10, f); push(3'd0, 31'd0, 16'd0);
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_state"}, env.env_state, 3'd0);
      check_eq({tag, "_busy"},  env.busy, 1'b0);
      check_eq({tag, "_amp"},   env.amplitude, 31'd0);
      check_eq({tag, "_freq"},  env.frequency, 16'd0);
   endtask

   // Output-change monitor: every change must match the next queued event.
   initial forever begin
      @(negedge clk);
      mon_snap = {env.busy, env.env_state, env.frequency, env.amplitude};
      if (mon_en && mon_snap !== prev_snap) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_event", {13'd0, mon_snap}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq("evt_state", env.env_state, mon_e.st);
            check_eq("evt_amp",   env.amplitude, mon_e.amp);
            check_eq("evt_freq",  env.frequency, mon_e.freq);
            check_eq("evt_busy",  env.busy, mon_e.st != 3'd0);
         end
      end
      prev_snap = mon_snap;
   end

   initial begin
      reset              = 1'b1;
      env.key_on         = 1'b0;
      env.key_freq       = 16'd440;
      env.peak_level     = 31'd100;
      env.sustain_level  = 31'd40;
      env.attack_step    = 16'd30;
      env.decay_step     = 16'd20;
      env.release_step   = 16'd10;
      @(posedge clk); #1;
      check_idle("reset");
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      reset  = 1'b0;

      // Basic ADSR
      @(negedge clk);
      push_attack_to_sustain(16'd440);
      env.key_on = 1'b1;
      wait_drain("adsr_attack_decay", 150);
      repeat (130) @(negedge clk);
      push_release_from_40(16'd440);
      env.key_on = 1'b0;
      wait_drain("adsr_release", 100);
      check_idle("adsr_end");

      // Retrigger during RELEASE
      push_attack_to_sustain(16'd440);
      env.key_on = 1'b1;
      wait_drain("retrig_first", 150);
      push(3'd4, 31'd40, 16'd440); push(3'd4, 31'd30, 16'd440); push(3'd4, 31'd20, 16'd440);
      env.key_on = 1'b0;
      wait_drain("retrig_release", 60);
      push(3'd1, 31'd20, 16'd523);  push(3'd1, 31'd50, 16'd523);  push(3'd1, 31'd80, 16'd523);
      push(3'd2, 31'd100, 16'd523); push(3'd2, 31'd80, 16'd523);  push(3'd2, 31'd60, 16'd523);
      push(3'd3, 31'd40, 16'd523);
      env.key_freq = 16'd523;
      env.key_on   = 1'b1;
      wait_drain("retrig_attack", 150);
      push_release_from_40(16'd523);
      env.key_on = 1'b0;
      wait_drain("retrig_end", 100);

      // Zero-frequency press
      env.key_freq = 16'd0;
      env.key_on   = 1'b1;
      repeat (3) @(negedge clk);
      env.key_on   = 1'b0;
      repeat (25) @(negedge clk);
      check_idle("zero_freq");

      // Degenerate steps and sustain clamping
      env.key_freq      = 16'd440;
      env.attack_step   = 16'd0;
      env.decay_step    = 16'd0;
      env.release_step  = 16'd0;
      env.sustain_level = 31'd150;
      push(3'd1, 31'd0, 16'd440); push(3'd2, 31'd100, 16'd440); push(3'd3, 31'd100, 16'd440);
      env.key_on = 1'b1;
      wait_drain("degen_attack", 60);
      push(3'd4, 31'd100, 16'd440); push(3'd0, 31'd0, 16'd0);
      env.key_on = 1'b0;
      wait_drain("degen_release", 60);
      env.attack_step   = 16'd30;
      env.decay_step    = 16'd20;
      env.release_step  = 16'd10;
      env.sustain_level = 31'd40;

      // Asynchronous reset mid-ATTACK
      push(3'd1, 31'd0, 16'd440); push(3'd1, 31'd30, 16'd440); push(3'd1, 31'd60, 16'd440);
      env.key_on = 1'b1;
      wait_drain("rst_pre", 60);
      @(posedge clk); #2;
      push(3'd0, 31'd0, 16'd0);
      reset = 1'b1;
      #1;
      check_idle("async_rst");
      push_attack_to_sustain(16'd440);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      nwait = 0;
      do begin
         @(posedge clk); #1;
         nwait++;
      end while (env.amplitude == 31'd0 && nwait < 40);
      check_eq("first_tick_latency", nwait, 10);
      wait_drain("rst_post", 150);

      // Key fall coinciding with a tick while in SUSTAIN
      nwait = 0;
      do begin
         @(negedge clk);
         nwait++;
      end while (cyc % 10 != 9 && nwait < 20);
      check_eq("tick_phase", cyc % 10, 9);
      push_release_from_40(16'd440);
      env.key_on = 1'b0;
      @(posedge clk); #1;
      check_eq("fall_tick_state", env.env_state, 3'd4);
      check_eq("fall_tick_amp",   env.amplitude, 31'd40);
      nwait = 0;
      do begin
         @(posedge clk); #1;
         nwait++;
      end while (env.amplitude == 31'd40 && nwait < 40);
      check_eq("fall_first_decrement_delay", nwait, 10);
      check_eq("fall_first_decrement_amp", env.amplitude, 31'd30);
      wait_drain("fall_tick_end", 100);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sine_envelope_controller.md
# sine_envelope_controller

ADSR envelope controller sitting in front of `SineWaveGenerator`. It turns a key press/release into the `frequency` and `amplitude` control words the oscillator consumes. Amplitude is stepped through attack, decay, sustain and release at a fixed envelope tick rate. `frequency` is driven to 0 when idle, which parks the generator in its own reset/zero-output condition.

## Interface
- `CLOCK_FREQUENCY`, default 50000000: system clock in Hz.
- `TICK_HZ`, default 1000: envelope update rate. `TICK_DIV = CLOCK_FREQUENCY / TICK_HZ` must be ≥ 2.
- `clk` input 1: system clock. All state is updated on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `key_on` input 1: level, synchronous to `clk`. High means the note is held.
- `key_freq` input 16: note frequency in Hz. Sampled on a `key_on` rising edge.
- `peak_level` input 31: attack target amplitude.
- `sustain_level` input 31: sustain amplitude. The effective value is `min(sustain_level, peak_level)`.
- `attack_step` input 16: amplitude increment per tick during ATTACK.
- `decay_step` input 16: amplitude decrement per tick during DECAY.
- `release_step` input 16: amplitude decrement per tick during RELEASE.
- `frequency` output 16: drives the generator's `frequency` input.
- `amplitude` output 31: drives the generator's `amplitude` input.
- `env_state` output 3: current state, encoded IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- `busy` output 1: high whenever `env_state` is not IDLE.

## Operation

**Tick prescaler**
- Free-running counter counting 0..`TICK_DIV`-1, then wrapping.
- `tick` is a one-cycle pulse when the counter equals `TICK_DIV`-1.
- The counter is not affected by key events.

**Key edge detection**
- Register `key_on` into `key_q`.
- `rise = key_on & ~key_q`; `fall = ~key_on & key_q`.

**Rising edge with `key_freq` ≠ 0** (accepted from any state)
- Latch `frequency <= key_freq` and enter ATTACK.
- `amplitude` is kept as-is (retrigger without click).

**Rising edge with `key_freq` = 0**
- The edge is ignored and the state is unchanged.

**ATTACK**
- On each tick: `amplitude <= min(amplitude + attack_step, peak_level)`.
- When the new value equals `peak_level`, go to DECAY.
- If `attack_step` = 0, jump to `peak_level` on the first tick.

**DECAY**
- On each tick: `amplitude <= max(amplitude - decay_step, sus)`, where `sus` is the effective sustain level.
- On reaching `sus`, go to SUSTAIN.
- If `decay_step` = 0, jump to `sus` on the first tick.

**SUSTAIN**
- Hold `amplitude`. Ticks have no effect.

**Release path**
- `key_on` low, or `fall`, while in ATTACK, DECAY or SUSTAIN: go to RELEASE. No amplitude change that cycle.

**RELEASE**
- On each tick: `amplitude <= max(amplitude - release_step, 0)`.
- On reaching 0, go to IDLE.
- If `release_step` = 0, jump to 0 on the first tick.
- A rising edge during RELEASE retriggers ATTACK from the current amplitude.

**IDLE**
- `frequency` = 0 and `amplitude` = 0.
- Only an accepted rising edge leaves IDLE.

**Arithmetic**
- Adds and subtracts are done at 32 bits with saturation; there is no wrap-around in either direction.
- `peak_level` and `sustain_level` are sampled live on every tick.

## Timing
- Reset is asynchronous. While `reset` is high, all of these hold immediately:
  - `frequency` = 0, `amplitude` = 0
  - `env_state` = IDLE, `busy` = 0
  - prescaler = 0, `key_q` = 0
- After reset deasserts, the first tick occurs on the `TICK_DIV`-th `clk` edge.
- Reset during any state aborts the note. No release phase is run.
- Rising edge: `key_on` goes high before edge N. After edge N, `env_state` = ATTACK and `frequency` = `key_freq`.
- Amplitude: the first increment appears after the first tick edge following ATTACK entry.
- Release: `key_on` goes low before edge N. After edge N, `env_state` = RELEASE.
- Release to idle: `frequency` goes to 0 on the same edge that takes `amplitude` to 0 and the state to IDLE.
- Priority when events coincide in one cycle: reset, then accepted rise, then key low/fall, then tick.
  - A tick that coincides with a state-changing key event is consumed with no amplitude step.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Basic ADSR.** Settings: `CLOCK_FREQUENCY`=1000, `TICK_HZ`=100 (`TICK_DIV`=10), peak=100, sustain=40, attack=30, decay=20, release=10, `key_freq`=440. Hold `key_on` for 200 cycles, then release.
  - Required amplitude sequence: 30, 60, 90, 100, 80, 60, 40; hold at 40.
  - After release: 30, 20, 10, 0; then IDLE with `frequency`=0.
- **Retrigger during RELEASE.** Same settings; release at amplitude 40, wait 2 ticks (amplitude 20), re-press.
  - Required: ATTACK resumes from 20, giving 50, 80, 100.
- **Zero-frequency press.** Pulse `key_on` with `key_freq`=0.
  - Required: stays IDLE, `busy`=0, outputs stay 0.
- **Degenerate steps and clamping.** `attack_step`=0, `decay_step`=0, sustain=150 (greater than peak=100).
  - Required: amplitude jumps to 100 on the first tick, DECAY resolves to 100, then SUSTAIN.
- **Asynchronous reset mid-ATTACK.** Assert `reset` between clock edges while amplitude is 60.
  - Required: all outputs 0 and IDLE before the next `clk` edge.
  - Required: after deassert, the first tick comes 10 cycles later.
- **Same-cycle key fall and tick.** Drive `key_on` low in the same cycle as a tick, while in SUSTAIN at 40.
  - Required: RELEASE entered with amplitude still 40; the first decrement (to 30) comes on the next tick.
